// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter: one log-shifter level per registered stage,
// LSB level first, with a global advance that stalls every stage at once.
module shift_unit_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  typedef enum logic [1:0] {
    MODE_SLL  = 2'b00,
    MODE_SRL  = 2'b01,
    MODE_SRA  = 2'b10,
    MODE_ROTL = 2'b11
  } mode_e;

  // One shifter level: move by a fixed power-of-two amount in the given mode.
  // SRA sign-extends from the current MSB, which equals the original MSB
  // because every earlier SRA level preserved it.
  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       mode,
    input int unsigned      amt
  );
    logic signed [WIDTH-1:0] sd;
    logic [WIDTH-1:0]        r;
    sd = d;
    case (mode)
      MODE_SLL:  r = d << amt;
      MODE_SRL:  r = d >> amt;
      MODE_SRA:  r = sd >>> amt;
      MODE_ROTL: r = (d << amt) | (d >> (WIDTH - amt));
      default:   r = d;
    endcase
    return r;
  endfunction

  // Per-stage registers; index k is the output of level k.
  logic [WIDTH-1:0]   data_q  [SHAMT_W];
  logic [WIDTH-1:0]   data_d  [SHAMT_W];
  logic [SHAMT_W-1:0] shamt_q [SHAMT_W];
  logic [SHAMT_W-1:0] shamt_d [SHAMT_W];
  logic [1:0]         mode_q  [SHAMT_W];
  logic [1:0]         mode_d  [SHAMT_W];
  logic [TAG_W-1:0]   tag_q   [SHAMT_W];
  logic [TAG_W-1:0]   tag_d   [SHAMT_W];
  logic [SHAMT_W-1:0] vld_q;
  logic [SHAMT_W-1:0] vld_d;

  // Inputs feeding each stage: the ports for stage 0, the previous stage otherwise.
  logic [WIDTH-1:0]   src_data  [SHAMT_W];
  logic [SHAMT_W-1:0] src_shamt [SHAMT_W];
  logic [1:0]         src_mode  [SHAMT_W];
  logic [TAG_W-1:0]   src_tag   [SHAMT_W];
  logic [SHAMT_W-1:0] src_vld;

  logic adv;

  // Whole pipe moves when the output slot is empty or being drained.
  assign adv       = !vld_q[SHAMT_W-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[SHAMT_W-1];
  assign out_data  = data_q[SHAMT_W-1];
  assign out_tag   = tag_q[SHAMT_W-1];

  // Next-state for every stage: hold on stall, otherwise load the predecessor
  // through its level (bubbles travel as cleared valid bits).
  always_comb begin
    src_data[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_mode[0]  = in_mode;
    src_tag[0]   = in_tag;
    src_vld      = '0;
    src_vld[0]   = in_valid;
    for (int k = 1; k < SHAMT_W; k++) begin
      src_data[k]  = data_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_tag[k]   = tag_q[k-1];
      src_vld[k]   = vld_q[k-1];
    end

    vld_d = vld_q;
    for (int k = 0; k < SHAMT_W; k++) begin
      data_d[k]  = data_q[k];
      shamt_d[k] = shamt_q[k];
      mode_d[k]  = mode_q[k];
      tag_d[k]   = tag_q[k];
      if (adv) begin
        data_d[k]  = src_shamt[k][k] ? shift_level(src_data[k], src_mode[k], 1 << k)
                                     : src_data[k];
        shamt_d[k] = src_shamt[k];
        mode_d[k]  = src_mode[k];
        tag_d[k]   = src_tag[k];
        vld_d[k]   = src_vld[k];
      end
    end
  end

  // Stage registers; reset clears control and data so nothing stale escapes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < SHAMT_W; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        mode_q[k]  <= '0;
        tag_q[k]   <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < SHAMT_W; k++) begin
        data_q[k]  <= data_d[k];
        shamt_q[k] <= shamt_d[k];
        mode_q[k]  <= mode_d[k];
        tag_q[k]   <= tag_d[k];
      end
    end
  end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Testbench for shift_unit_pipe: directed scenarios plus a randomized run,
// with a scoreboard that predicts every result from the shift rules.
module tb_shift_unit_pipe;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int TAG_W   = 5;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_mode;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  logic [WIDTH-1:0] exp_data_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];

  shift_unit_pipe #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: shift through a double-width word and pick the right half.
  function automatic logic [31:0] ref_shift(logic [31:0] d, logic [4:0] s, logic [1:0] m);
    logic [63:0] w;
    int n;
    n = int'(s);
    case (m)
      2'b00:   begin w = {32'b0, d} << n;        return w[31:0];  end
      2'b01:   begin w = {32'b0, d} >> n;        return w[31:0];  end
      2'b10:   begin w = {{32{d[31]}}, d} >> n;  return w[31:0];  end
      default: begin w = {d, d} << n;            return w[63:32]; end
    endcase
  endfunction

  // Scoreboard: record accepted ops, check each consumed result in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_data_q.delete();
      exp_tag_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        total++;
        if (exp_data_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got data=%h tag=%0d, required no result", out_data, out_tag);
        end else begin
          logic [31:0] ed;
          logic [4:0]  et;
          ed = exp_data_q.pop_front();
          et = exp_tag_q.pop_front();
          if (out_data !== ed || out_tag !== et) begin
            bad++;
            $display("FAIL sb_result: got data=%h tag=%0d, required data=%h tag=%0d",
                     out_data, out_tag, ed, et);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_data_q.push_back(ref_shift(in_data, in_shamt, in_mode));
        exp_tag_q.push_back(in_tag);
      end
    end
  end

  // Offer one op, wait for acceptance, then withdraw it (called at posedge+1).
  task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                      input logic [4:0] t);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_shamt = s; in_mode = m; in_tag = t;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s_timeout: out_valid=0, required 1", name);
    end
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_data_q.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1;
    total++;
    if (exp_data_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: pending=%0d, required 0", name, exp_data_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'd0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b d=%h t=%0d, required 0/0/0", out_valid, out_data, out_tag);
    end
    out_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  task automatic test_legacy();
    send(32'h0000_1234, 5'd2, 2'b00, 5'd7);
    // accepted on the edge just passed; result must show on the fifth edge
    for (int c = 1; c <= 5; c++) begin
      total++;
      if (out_valid !== (c == 5)) begin
        bad++;
        $display("FAIL legacy_latency: edge %0d out_valid=%b, required %b", c, out_valid, c == 5);
      end
      if (c < 5) begin @(posedge clk); #1; end
    end
    total++;
    if (out_data !== 32'h0000_48D0 || out_tag !== 5'd7) begin
      bad++;
      $display("FAIL legacy_value: got d=%h t=%0d, required 000048d0/7", out_data, out_tag);
    end
    drain("legacy");
  endtask

  task automatic test_corners();
    logic [31:0] cd [7] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0001,
                            32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'hA5A5_0F0F};
    logic [4:0]  cs [7] = '{5'd31, 5'd31, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [1:0]  cm [7] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] ce [7] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0003,
                            32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'hA5A5_0F0F};
    for (int i = 0; i < 7; i++) begin
      send(cd[i], cs[i], cm[i], 5'(i + 10));
      wait_out("corner");
      total++;
      if (out_data !== ce[i] || out_tag !== 5'(i + 10)) begin
        bad++;
        $display("FAIL corner_%0d: got d=%h t=%0d, required d=%h t=%0d",
                 i, out_data, out_tag, ce[i], i + 10);
      end
      @(posedge clk); #1;
    end
    drain("corner");
  endtask

  task automatic test_back_to_back();
    fork
      begin
        for (int i = 0; i < 8; i++)
          send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 5'(i));
      end
      begin
        wait_out("b2b");
        for (int j = 0; j < 8; j++) begin
          total++;
          if (out_valid !== 1'b1 || out_tag !== 5'(j)) begin
            bad++;
            $display("FAIL b2b_seq_%0d: got v=%b t=%0d, required v=1 t=%0d", j, out_valid, out_tag, j);
          end
          @(negedge clk);
        end
      end
    join
    drain("b2b");
  endtask

  task automatic test_stall();
    logic [31:0] hd;
    logic [4:0]  ht;
    int          n0;
    n0 = n_out;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 5'(20 + i));
    wait_out("stall");
    hd = out_data; ht = out_tag;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== hd || out_tag !== ht) begin
        bad++;
        $display("FAIL stall_hold_%0d: got rdy=%b v=%b d=%h t=%0d, required rdy=0 v=1 d=%h t=%0d",
                 c, in_ready, out_valid, out_data, out_tag, hd, ht);
      end
    end
    @(posedge clk); #1;
    drain("stall");
    total++;
    if (n_out - n0 != 3) begin
      bad++;
      $display("FAIL stall_count: got %0d results, required 3", n_out - n0);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 5'(i));
    wait_out("midrst");
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'd0) begin
      bad++;
      $display("FAIL midrst_drop: got v=%b d=%h t=%0d, required 0/0/0", out_valid, out_data, out_tag);
    end
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL midrst_stale_%0d: got out_valid=%b, required 0", c, out_valid);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit done;
    int n0;
    done = 1'b0;
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 5'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain("random");
    total++;
    if (n_out - n0 != 1000) begin
      bad++;
      $display("FAIL random_count: got %0d results, required 1000", n_out - n0);
    end
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_corners();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
